// File: rtl/issue_pkg.sv
// Shared types for the unified issue queue: dispatch/issue payloads, the
// resident entry record and the CDB tag matcher used by both capture and
// resident wakeup.
package issue_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 8;
    localparam int CDB_W  = 4;
    localparam int CDB_LW = (CDB_W > 1) ? $clog2(CDB_W) : 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst_tag;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  q1;
        logic              r1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  q2;
        logic              r2;
    } iq_disp_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst_tag;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
    } iq_iss_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  q1;
        logic              r1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  q2;
        logic              r2;
    } iq_entry_t;

    typedef struct packed {
        logic              hit;
        logic [CDB_LW-1:0] lane;
    } cdb_hit_t;

    // Ascending scan so that the highest matching lane is the one reported.
    function automatic cdb_hit_t cdb_match(
        input logic [TAG_W-1:0]            tag,
        input logic [CDB_W-1:0]            cdb_valid,
        input logic [CDB_W-1:0][TAG_W-1:0] cdb_tag
    );
        cdb_hit_t res;
        res = '0;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && (cdb_tag[c] == tag)) begin
                res.hit  = 1'b1;
                res.lane = CDB_LW'(c);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue. r_older[i][j] = 1 means entry j is older
// than entry i. New entries are younger than every survivor; same-cycle
// allocations are ordered by dispatch lane. Select hands port p the ready
// entry that has exactly p older ready entries.
module iq_age_matrix
    import issue_pkg::*;
#(
    parameter  int RS_DEPTH = 8,
    parameter  int DISP_W   = 4,
    parameter  int ISSUE_W  = 4,
    localparam int LANE_W   = (DISP_W > 1) ? $clog2(DISP_W) : 1,
    localparam int CNT_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_flush,
    input  logic [RS_DEPTH-1:0]                i_valid,
    input  logic [RS_DEPTH-1:0]                i_alloc,
    input  logic [RS_DEPTH-1:0][LANE_W-1:0]    i_alloc_lane,
    input  logic [RS_DEPTH-1:0]                i_free,
    input  logic [RS_DEPTH-1:0]                i_ready,
    output logic [ISSUE_W-1:0][RS_DEPTH-1:0]   o_sel
);

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_older;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] w_older_nxt;

    function automatic logic [CNT_W-1:0] f_popcnt(input logic [RS_DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Next matrix: fresh rows for allocations, cleared row/column for frees.
    always_comb begin
        logic [RS_DEPTH-1:0] row;
        row         = '0;
        w_older_nxt = r_older;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (i_alloc[i]) begin
                row = i_valid & ~i_free;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (i_alloc[j] && (i_alloc_lane[j] < i_alloc_lane[i])) begin
                        row[j] = 1'b1;
                    end
                end
                w_older_nxt[i] = row;
            end else if (!i_valid[i] || i_free[i]) begin
                w_older_nxt[i] = '0;
            end else begin
                w_older_nxt[i] = r_older[i] & ~i_free;
            end
        end
    end

    // Matrix state; flush drops every ordering relation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_older <= '0;
        end else if (i_flush) begin
            r_older <= '0;
        end else begin
            r_older <= w_older_nxt;
        end
    end

    // Rank each ready entry by how many ready entries are older than it.
    always_comb begin
        logic [CNT_W-1:0] rank;
        rank  = '0;
        o_sel = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            rank = f_popcnt(r_older[i] & i_ready);
            for (int p = 0; p < ISSUE_W; p++) begin
                if (i_ready[i] && (rank == CNT_W'(p))) begin
                    o_sel[p][i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Unified reservation station: slot allocation, CDB wakeup (at capture and
// while resident) and age-ordered multi-port issue.
// Optional feature macro: IQ_CDB_BYPASS_EN -- when defined, resident operands
// matching a same-cycle CDB lane count as ready and their issue payload takes
// the broadcast value (zero-cycle wakeup-to-issue). When undefined there is no
// CDB-to-issue combinational path.
module issue_queue
    import issue_pkg::*;
#(
    parameter  int RS_DEPTH = 8,
    parameter  int DISP_W   = 4,
    parameter  int ISSUE_W  = 4,
    localparam int CNT_W    = $clog2(RS_DEPTH + 1),
    localparam int LANE_W   = (DISP_W > 1) ? $clog2(DISP_W) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_i,
    input  logic                              head_en_i,
    input  logic [TAG_W-1:0]                  head_tag_i,
    input  logic [DISP_W-1:0]                 disp_valid_i,
    output logic                              disp_ready_o,
    input  iq_disp_t [DISP_W-1:0]             disp_uop_i,
    input  logic [CDB_W-1:0]                  cdb_valid_i,
    input  logic [CDB_W-1:0][TAG_W-1:0]       cdb_tag_i,
    input  logic [CDB_W-1:0][DATA_W-1:0]      cdb_value_i,
    output logic [ISSUE_W-1:0]                iss_valid_o,
    input  logic [ISSUE_W-1:0]                iss_ready_i,
    output iq_iss_t [ISSUE_W-1:0]             iss_uop_o,
    output logic [CNT_W-1:0]                  free_cnt_o
);

    iq_entry_t                         r_ent [RS_DEPTH];
    logic [CNT_W-1:0]                  r_free_cnt;
    logic                              r_disp_ready;

    logic [RS_DEPTH-1:0]               w_valid;
    logic [RS_DEPTH-1:0]               w_op1_ok;
    logic [RS_DEPTH-1:0]               w_op2_ok;
    logic [RS_DEPTH-1:0]               w_ready;
    logic [RS_DEPTH-1:0]               w_alloc;
    logic [RS_DEPTH-1:0]               w_free;
    logic [RS_DEPTH-1:0][LANE_W-1:0]   w_alloc_lane;
    logic [ISSUE_W-1:0][RS_DEPTH-1:0]  w_sel;
    logic [DISP_W-1:0]                 w_acc;
    cdb_hit_t                          w_hit1 [RS_DEPTH];
    cdb_hit_t                          w_hit2 [RS_DEPTH];
    cdb_hit_t                          w_dhit1 [DISP_W];
    cdb_hit_t                          w_dhit2 [DISP_W];
    iq_entry_t                         w_cap [DISP_W];
    logic [CNT_W-1:0]                  w_free_cnt_nxt;

    function automatic logic [CNT_W-1:0] f_popcnt(input logic [RS_DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    assign disp_ready_o = r_disp_ready;
    assign free_cnt_o   = r_free_cnt;

    // Resident CDB matching and the registered-state ready mask.
    always_comb begin
        w_valid  = '0;
        w_op1_ok = '0;
        w_op2_ok = '0;
        w_ready  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_hit1[i]  = cdb_match(r_ent[i].q1, cdb_valid_i, cdb_tag_i);
            w_hit2[i]  = cdb_match(r_ent[i].q2, cdb_valid_i, cdb_tag_i);
`ifdef IQ_CDB_BYPASS_EN
            w_op1_ok[i] = r_ent[i].r1 || w_hit1[i].hit;
            w_op2_ok[i] = r_ent[i].r2 || w_hit2[i].hit;
`else
            w_op1_ok[i] = r_ent[i].r1;
            w_op2_ok[i] = r_ent[i].r2;
`endif
            w_ready[i] = r_ent[i].valid && w_op1_ok[i] && w_op2_ok[i] &&
                         (!head_en_i || (r_ent[i].dst == head_tag_i));
        end
    end

    // Build the entry each dispatch lane would write, with capture wakeup.
    always_comb begin
        for (int l = 0; l < DISP_W; l++) begin
            w_dhit1[l]       = cdb_match(disp_uop_i[l].q1, cdb_valid_i, cdb_tag_i);
            w_dhit2[l]       = cdb_match(disp_uop_i[l].q2, cdb_valid_i, cdb_tag_i);
            w_cap[l].valid   = 1'b1;
            w_cap[l].op      = disp_uop_i[l].op;
            w_cap[l].dst     = disp_uop_i[l].dst_tag;
            w_cap[l].q1      = disp_uop_i[l].q1;
            w_cap[l].q2      = disp_uop_i[l].q2;
            w_cap[l].r1      = disp_uop_i[l].r1 || w_dhit1[l].hit;
            w_cap[l].r2      = disp_uop_i[l].r2 || w_dhit2[l].hit;
            w_cap[l].v1      = (!disp_uop_i[l].r1 && w_dhit1[l].hit) ?
                               cdb_value_i[w_dhit1[l].lane] : disp_uop_i[l].v1;
            w_cap[l].v2      = (!disp_uop_i[l].r2 && w_dhit2[l].hit) ?
                               cdb_value_i[w_dhit2[l].lane] : disp_uop_i[l].v2;
        end
    end

    // Allocator: accepted lanes take free slots lowest-index-first in lane order.
    // Slots freed by issue this cycle are still valid here, so never reused early.
    always_comb begin
        logic [RS_DEPTH-1:0] avail;
        logic                found;
        avail        = ~w_valid;
        found        = 1'b0;
        w_alloc      = '0;
        w_alloc_lane = '0;
        w_acc        = disp_valid_i & {DISP_W{r_disp_ready & ~flush_i}};
        for (int l = 0; l < DISP_W; l++) begin
            found = 1'b0;
            if (w_acc[l]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (!found && avail[i]) begin
                        found           = 1'b1;
                        avail[i]        = 1'b0;
                        w_alloc[i]      = 1'b1;
                        w_alloc_lane[i] = LANE_W'(l);
                    end
                end
            end
        end
    end

    iq_age_matrix #(
        .RS_DEPTH (RS_DEPTH),
        .DISP_W   (DISP_W),
        .ISSUE_W  (ISSUE_W)
    ) u_age (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush_i),
        .i_valid      (w_valid),
        .i_alloc      (w_alloc),
        .i_alloc_lane (w_alloc_lane),
        .i_free       (w_free),
        .i_ready      (w_ready),
        .o_sel        (w_sel)
    );

    // Issue port muxes and the per-entry free vector from completed handshakes.
    always_comb begin
        iss_valid_o = '0;
        iss_uop_o   = '0;
        w_free      = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            iss_valid_o[p] = (|w_sel[p]) && !flush_i;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_sel[p][i]) begin
                    iss_uop_o[p].op      = r_ent[i].op;
                    iss_uop_o[p].dst_tag = r_ent[i].dst;
`ifdef IQ_CDB_BYPASS_EN
                    iss_uop_o[p].v1 = r_ent[i].r1 ? r_ent[i].v1 : cdb_value_i[w_hit1[i].lane];
                    iss_uop_o[p].v2 = r_ent[i].r2 ? r_ent[i].v2 : cdb_value_i[w_hit2[i].lane];
`else
                    iss_uop_o[p].v1 = r_ent[i].v1;
                    iss_uop_o[p].v2 = r_ent[i].v2;
`endif
                    w_free[i] = w_free[i] | (iss_valid_o[p] && iss_ready_i[p]);
                end
            end
        end
    end

    assign w_free_cnt_nxt = r_free_cnt - f_popcnt(RS_DEPTH'(w_acc)) + f_popcnt(w_free);

    // Free-entry counter and the registered dispatch-ready derived from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free_cnt   <= CNT_W'(RS_DEPTH);
            r_disp_ready <= 1'b1;
        end else if (flush_i) begin
            r_free_cnt   <= CNT_W'(RS_DEPTH);
            r_disp_ready <= 1'b1;
        end else begin
            r_free_cnt   <= w_free_cnt_nxt;
            r_disp_ready <= (w_free_cnt_nxt >= CNT_W'(DISP_W));
        end
    end

    // Entry storage: only the valid bit is reset; payload is don't-care when invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (flush_i) begin
                    r_ent[i].valid <= 1'b0;
                end else if (w_alloc[i]) begin
                    r_ent[i] <= w_cap[w_alloc_lane[i]];
                end else if (w_free[i]) begin
                    r_ent[i].valid <= 1'b0;
                end else if (r_ent[i].valid) begin
                    if (!r_ent[i].r1 && w_hit1[i].hit) begin
                        r_ent[i].r1 <= 1'b1;
                        r_ent[i].v1 <= cdb_value_i[w_hit1[i].lane];
                    end
                    if (!r_ent[i].r2 && w_hit2[i].hit) begin
                        r_ent[i].r2 <= 1'b1;
                        r_ent[i].v2 <= cdb_value_i[w_hit2[i].lane];
                    end
                end
            end
        end
    end

    // Counter stays within [0, RS_DEPTH] and tracks the number of empty slots.
    a_free_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_free_cnt <= CNT_W'(RS_DEPTH));
    a_free_match: assert property (@(posedge clk) disable iff (!rst_n)
        r_free_cnt == f_popcnt(~w_valid));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        f_popcnt(RS_DEPTH'(w_acc)) <= r_free_cnt);

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios with an issue
// scoreboard that expects uops to leave in a known age order.
module tb_issue_queue;
    import issue_pkg::*;

    localparam int RS_DEPTH = 8;
    localparam int DISP_W   = 4;
    localparam int ISSUE_W  = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         flush = 1'b0;
    logic                         head_en = 1'b0;
    logic [TAG_W-1:0]             head_tag = '0;
    logic [DISP_W-1:0]            disp_valid = '0;
    logic                         disp_ready;
    iq_disp_t [DISP_W-1:0]        disp_uop = '0;
    logic [CDB_W-1:0]             cdb_valid = '0;
    logic [CDB_W-1:0][TAG_W-1:0]  cdb_tag = '0;
    logic [CDB_W-1:0][DATA_W-1:0] cdb_value = '0;
    logic [ISSUE_W-1:0]           iss_valid;
    logic [ISSUE_W-1:0]           iss_ready = '0;
    iq_iss_t [ISSUE_W-1:0]        iss_uop;
    logic [3:0]                   free_cnt;

    int      n_chk = 0;
    int      n_err = 0;
    iq_iss_t sb[$];
    iq_iss_t mon_e;

    issue_queue #(.RS_DEPTH(RS_DEPTH), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .head_en_i    (head_en),
        .head_tag_i   (head_tag),
        .disp_valid_i (disp_valid),
        .disp_ready_o (disp_ready),
        .disp_uop_i   (disp_uop),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .cdb_value_i  (cdb_value),
        .iss_valid_o  (iss_valid),
        .iss_ready_i  (iss_ready),
        .iss_uop_o    (iss_uop),
        .free_cnt_o   (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] va(input int d);
        return 32'h1000_0000 + 32'(d);
    endfunction

    function automatic logic [31:0] vb(input int d);
        return 32'h2000_0000 + 32'(d);
    endfunction

    function automatic iq_iss_t mk_iss(input int dst, input logic [31:0] v1, input logic [31:0] v2);
        iq_iss_t e;
        e.op      = OP_W'(dst + 128);
        e.dst_tag = TAG_W'(dst);
        e.v1      = v1;
        e.v2      = v2;
        return e;
    endfunction

    task automatic put(input int l, input int dst,
                       input logic r1, input int q1, input logic [31:0] v1,
                       input logic r2, input int q2, input logic [31:0] v2);
        disp_uop[l].op      = OP_W'(dst + 128);
        disp_uop[l].dst_tag = TAG_W'(dst);
        disp_uop[l].r1      = r1;
        disp_uop[l].q1      = TAG_W'(q1);
        disp_uop[l].v1      = v1;
        disp_uop[l].r2      = r2;
        disp_uop[l].q2      = TAG_W'(q2);
        disp_uop[l].v2      = v2;
        disp_valid[l]       = 1'b1;
    endtask

    task automatic cdb(input int lane, input int tag, input logic [31:0] val);
        cdb_valid[lane] = 1'b1;
        cdb_tag[lane]   = TAG_W'(tag);
        cdb_value[lane] = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        disp_valid = '0;
        cdb_valid  = '0;
    endtask

    // Every completed issue handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < ISSUE_W; p++) begin
                if (iss_valid[p] && iss_ready[p]) begin
                    chk("sb_has_entry", 128'(sb.size() > 0), 128'd1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        chk($sformatf("iss_p%0d", p), 128'(iss_uop[p]), 128'(mon_e));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_free", free_cnt, 8);
        chk("rst_drdy", disp_ready, 1);
        chk("rst_ivld", iss_valid, 0);
        rst_n = 1'b1;
        tick();

        // 1: four ready uops, all issue next cycle in lane order
        iss_ready = 4'hF;
        for (int l = 0; l < 4; l++) begin
            put(l, l + 1, 1'b1, 0, va(l + 1), 1'b1, 0, vb(l + 1));
            sb.push_back(mk_iss(l + 1, va(l + 1), vb(l + 1)));
        end
        tick(); clr();
        chk("t1_ivld", iss_valid, 4'hF);
        chk("t1_free_mid", free_cnt, 4);
        chk("t1_p3_dst", iss_uop[3].dst_tag, 4);
        tick();
        chk("t1_free", free_cnt, 8);
        chk("t1_ivld_after", iss_valid, 0);

        // 2: fill with uops waiting on tag 9, then wake them with CDB lane 2
        iss_ready = 4'h0;
        for (int l = 0; l < 4; l++) put(l, 10 + l, 1'b0, 9, 32'hBAD0_0000, 1'b1, 0, vb(10 + l));
        tick(); clr();
        chk("t2_free4", free_cnt, 4);
        chk("t2_drdy1", disp_ready, 1);
        for (int l = 0; l < 4; l++) put(l, 14 + l, 1'b0, 9, 32'hBAD0_0000, 1'b1, 0, vb(14 + l));
        tick(); clr();
        chk("t2_free0", free_cnt, 0);
        chk("t2_drdy0", disp_ready, 0);
        put(0, 30, 1'b1, 0, va(30), 1'b1, 0, vb(30));
        tick(); clr();
        chk("t2_full_hold", free_cnt, 0);
        for (int d = 10; d < 18; d++) sb.push_back(mk_iss(d, 32'h0000_DEAD, vb(d)));
        iss_ready = 4'hF;
        cdb(1, 9, 32'h0000_1111);
        cdb(2, 9, 32'h0000_DEAD);
        #1;
`ifdef IQ_CDB_BYPASS_EN
        chk("t2_same_cycle", iss_valid, 4'hF);
`else
        chk("t2_no_bypass", iss_valid, 4'h0);
`endif
        tick(); clr();
        chk("t2_ivld", iss_valid, 4'hF);
        chk("t2_p0_v1", iss_uop[0].v1, 32'h0000_DEAD);
        tick();
        tick();
        chk("t2_free", free_cnt, 8);

        // 3: age order -- older A wakes after younger B is ready
        put(0, 5, 1'b0, 20, 32'hBAD0_0000, 1'b1, 0, vb(5));
        sb.push_back(mk_iss(5, 32'h0000_0077, vb(5)));
        tick(); clr();
        iss_ready = 4'h0;
        put(3, 6, 1'b1, 0, va(6), 1'b1, 0, vb(6));
        sb.push_back(mk_iss(6, va(6), vb(6)));
        tick(); clr();
        chk("t3_b_only", iss_valid, 4'b0001);
        chk("t3_b_p0", iss_uop[0].dst_tag, 6);
        cdb(0, 20, 32'h0000_0077);
        tick(); clr();
        chk("t3_both", iss_valid, 4'b0011);
        chk("t3_a_p0", iss_uop[0].dst_tag, 5);
        chk("t3_b_p1", iss_uop[1].dst_tag, 6);
        iss_ready = 4'hF;
        tick();
        chk("t3_free", free_cnt, 8);

        // 4: stall port 0 for three cycles
        iss_ready = 4'h0;
        put(0, 40, 1'b1, 0, va(40), 1'b1, 0, vb(40));
        sb.push_back(mk_iss(40, va(40), vb(40)));
        tick(); clr();
        chk("t4_stall0", {iss_valid, free_cnt}, {4'b0001, 4'd7});
        for (int k = 1; k < 3; k++) begin
            tick();
            chk($sformatf("t4_stall%0d", k), {iss_valid, free_cnt}, {4'b0001, 4'd7});
        end
        iss_ready = 4'b0001;
        tick();
        chk("t4_free", free_cnt, 8);

        // 5: capture wakeup on src2 in the dispatch cycle
        iss_ready = 4'h0;
        put(0, 41, 1'b1, 0, va(41), 1'b0, 7, 32'hBAD0_0000);
        cdb(3, 7, 32'h0000_0055);
        sb.push_back(mk_iss(41, va(41), 32'h0000_0055));
        tick(); clr();
        chk("t5_ready", iss_valid, 4'b0001);
        chk("t5_v2", iss_uop[0].v2, 32'h0000_0055);
        iss_ready = 4'hF;
        tick();
        chk("t5_free", free_cnt, 8);

        // 6: flush with six resident ready entries and dispatch asserted
        iss_ready = 4'h0;
        for (int l = 0; l < 4; l++) put(l, 50 + l, 1'b1, 0, va(50 + l), 1'b1, 0, vb(50 + l));
        tick(); clr();
        put(0, 54, 1'b1, 0, va(54), 1'b1, 0, vb(54));
        put(1, 55, 1'b1, 0, va(55), 1'b1, 0, vb(55));
        tick(); clr();
        chk("t6_free2", free_cnt, 2);
        chk("t6_drdy0", disp_ready, 0);
        for (int l = 0; l < 4; l++) put(l, 56 + l, 1'b1, 0, va(56 + l), 1'b1, 0, vb(56 + l));
        flush = 1'b1;
        iss_ready = 4'hF;
        #1;
        chk("t6_ivld_flush", iss_valid, 0);
        tick();
        flush = 1'b0;
        clr();
        chk("t6_ivld", iss_valid, 0);
        chk("t6_free", free_cnt, 8);
        chk("t6_drdy", disp_ready, 1);
        repeat (3) tick();

        // 6b: serialize mode -- only the head tag may issue
        iss_ready = 4'h0;
        head_en   = 1'b1;
        head_tag  = TAG_W'(3);
        for (int l = 0; l < 4; l++) put(l, l + 1, 1'b1, 0, va(l + 1), 1'b1, 0, vb(l + 1));
        sb.push_back(mk_iss(3, va(3), vb(3)));
        sb.push_back(mk_iss(1, va(1), vb(1)));
        sb.push_back(mk_iss(2, va(2), vb(2)));
        sb.push_back(mk_iss(4, va(4), vb(4)));
        tick(); clr();
        chk("t6_head_vld", iss_valid, 4'b0001);
        chk("t6_head_dst", iss_uop[0].dst_tag, 3);
        iss_ready = 4'hF;
        tick();
        head_en = 1'b0;
        #1;
        chk("t6_rest_vld", iss_valid, 4'b0111);
        tick();
        chk("t6_head_free", free_cnt, 8);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
